// File: rtl/im_vga_ctrl_if.sv
// Bundle between the VGA scan-out controller, the host/register side and the image memory.
// Latency: none (wires only).
// Backpressure: none; the host strobes requests, the memory answers at a fixed latency.
interface im_vga_ctrl_if #(
  parameter int ISEL_W = 8
);
  logic              en;
  logic [ISEL_W-1:0] isel_req;
  logic              isel_req_valid;
  logic [ISEL_W-1:0] isel;
  logic              isel_pending;
  logic [9:0]        pixel_x;
  logic [9:0]        pixel_y;
  logic [11:0]       mem_rgb;
  logic [3:0]        vga_r;
  logic [3:0]        vga_g;
  logic [3:0]        vga_b;
  logic              vga_hs;
  logic              vga_vs;
  logic              frame_start;

  // Controller side.
  modport master (
    input  en, isel_req, isel_req_valid, mem_rgb,
    output isel, isel_pending, pixel_x, pixel_y,
           vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start
  );

  // Host / memory / connector side.
  modport slave (
    output en, isel_req, isel_req_valid, mem_rgb,
    input  isel, isel_pending, pixel_x, pixel_y,
           vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start
  );
endinterface

// File: rtl/im_vga_ctrl.sv
// VGA scan-out controller: pixel/line counters, syncs, RGB realignment, frame-boundary image select.
// Latency: RGB and syncs appear one pixel period (CLK_DIV clks) after pixel_x/pixel_y.
// Backpressure: none; image-select requests are held pending until a frame wrap.
// Optional: define IM_VGA_SLIDESHOW_EN to auto-advance isel every SLIDE_FRAMES frames.
module im_vga_ctrl #(
  parameter int CLK_DIV      = 4,
  parameter int MEM_LAT      = 1,
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int ISEL_W       = 8,
  parameter int NUM_IMG      = 2,
  parameter int SLIDE_FRAMES = 60
) (
  input  logic           clk,
  input  logic           rst,
  im_vga_ctrl_if.master  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // The memory must answer within one pixel period, otherwise the realigned RGB is stale.
  if (CLK_DIV < MEM_LAT + 1 || NUM_IMG < 1 || SLIDE_FRAMES < 1) begin : g_param_check
    $error("im_vga_ctrl: CLK_DIV must be >= MEM_LAT+1, NUM_IMG and SLIDE_FRAMES >= 1");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nxt;
  logic              run;
  logic [DIV_W-1:0]  div_cnt;
  logic [9:0]        h_cnt, v_cnt;
  logic              pix_tick, h_last, v_last, frame_wrap;
  logic              active, hs_raw, vs_raw;
  logic [11:0]       rgb_q;
  logic              hs_q, vs_q, fs_q;
  logic [ISEL_W-1:0] isel_q, isel_nxt, pend_val, pend_val_nxt;
  logic              pend_q, pend_nxt;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state; counting follows en directly so the first pixel tick lands CLK_DIV clks after en rises.
  always_comb begin
    state_nxt = state;
    run       = bus.en;
    case (state)
      IDLE:    if (bus.en)  state_nxt = RUN;
      RUN:     if (!bus.en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign pix_tick   = run && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign h_last     = (h_cnt == 10'(H_TOTAL - 1));
  assign v_last     = (v_cnt == 10'(V_TOTAL - 1));
  assign frame_wrap = pix_tick && h_last && v_last;
  assign active     = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
  assign hs_raw     = !((h_cnt >= 10'(H_ACTIVE + H_FP)) && (h_cnt < 10'(H_ACTIVE + H_FP + H_SYNC)));
  assign vs_raw     = !((v_cnt >= 10'(V_ACTIVE + V_FP)) && (v_cnt < 10'(V_ACTIVE + V_FP + V_SYNC)));

  // Clock divider and raster counters; cleared whenever scanning is disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else if (!run) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else if (pix_tick) begin
      div_cnt <= '0;
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Output stage: capture the memory answer and syncs for the pixel that is about to advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else if (!run) begin
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else if (pix_tick) begin
      rgb_q <= active ? bus.mem_rgb : 12'h000;
      hs_q  <= hs_raw;
      vs_q  <= vs_raw;
    end
  end

`ifdef IM_VGA_SLIDESHOW_EN
  localparam int FCNT_W = $clog2(SLIDE_FRAMES + 1);
  logic [FCNT_W-1:0] fcnt, fcnt_nxt;
  logic [ISEL_W-1:0] slide_next;
  assign slide_next = (isel_q >= ISEL_W'(NUM_IMG - 1)) ? '0 : isel_q + 1'b1;
`endif

  // Image-select scheduling: apply at frame wrap (or at once when idle); a coinciding strobe waits a frame.
  always_comb begin
    isel_nxt     = isel_q;
    pend_nxt     = pend_q;
    pend_val_nxt = pend_val;
`ifdef IM_VGA_SLIDESHOW_EN
    fcnt_nxt     = fcnt;
    if (!run) begin
      fcnt_nxt = '0;
    end else if (frame_wrap) begin
      if (pend_q) begin
        fcnt_nxt = '0;
      end else if (fcnt == FCNT_W'(SLIDE_FRAMES - 1)) begin
        fcnt_nxt = '0;
        isel_nxt = slide_next;
      end else begin
        fcnt_nxt = fcnt + 1'b1;
      end
    end
`endif
    if (pend_q && (frame_wrap || state == IDLE)) begin
      isel_nxt = pend_val;
      pend_nxt = 1'b0;
    end
    if (bus.isel_req_valid) begin
      pend_val_nxt = bus.isel_req;
      pend_nxt     = 1'b1;
    end
  end

  // Image-select and frame-start registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      isel_q   <= '0;
      pend_q   <= 1'b0;
      pend_val <= '0;
      fs_q     <= 1'b0;
`ifdef IM_VGA_SLIDESHOW_EN
      fcnt     <= '0;
`endif
    end else begin
      isel_q   <= isel_nxt;
      pend_q   <= pend_nxt;
      pend_val <= pend_val_nxt;
      fs_q     <= frame_wrap;
`ifdef IM_VGA_SLIDESHOW_EN
      fcnt     <= fcnt_nxt;
`endif
    end
  end

  assign bus.isel         = isel_q;
  assign bus.isel_pending = pend_q;
  assign bus.pixel_x      = h_cnt;
  assign bus.pixel_y      = v_cnt;
  assign bus.vga_r        = rgb_q[11:8];
  assign bus.vga_g        = rgb_q[7:4];
  assign bus.vga_b        = rgb_q[3:0];
  assign bus.vga_hs       = hs_q;
  assign bus.vga_vs       = vs_q;
  assign bus.frame_start  = fs_q;

endmodule

// File: tb/tb_im_vga_ctrl.sv
// Directed bench for im_vga_ctrl on a shrunken raster (15x8 pixels, CLK_DIV=4, 480 clks per frame).
// Expected values are hand-computed: after k clks from en rising, the counters hold pixel floor(k/4),
// and the outputs show the pixel before it. Slideshow expectations follow IM_VGA_SLIDESHOW_EN.
module tb_im_vga_ctrl;
  localparam int CLK_DIV = 4;
  localparam int SLIDE   = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   k     = 0;
  logic [11:0] rgb;

  im_vga_ctrl_if #(.ISEL_W(8)) bus ();

  im_vga_ctrl #(
    .CLK_DIV(CLK_DIV), .MEM_LAT(1),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .ISEL_W(8), .NUM_IMG(2), .SLIDE_FRAMES(SLIDE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Image memory with one clk of read latency.
  always @(posedge clk) bus.mem_rgb <= {bus.pixel_x[3:0], bus.pixel_y[3:0], 4'hA};

  assign rgb = {bus.vga_r, bus.vga_g, bus.vga_b};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic goto(input int t);
    if (t > k) adv(t - k);
  endtask

  task automatic strobe(input logic [7:0] v);
    bus.isel_req       = v;
    bus.isel_req_valid = 1'b1;
    adv(1);
    bus.isel_req_valid = 1'b0;
  endtask

  initial begin
    rst                = 1'b0;
    bus.en             = 1'b0;
    bus.isel_req       = '0;
    bus.isel_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_isel", bus.isel, 0);
    check("rst_pend", bus.isel_pending, 0);
    check("rst_px", bus.pixel_x, 0);
    check("rst_py", bus.pixel_y, 0);
    check("rst_rgb", rgb, 0);
    check("rst_hs", bus.vga_hs, 1);
    check("rst_vs", bus.vga_vs, 1);
    check("rst_fs", bus.frame_start, 0);
    rst = 1'b1;
    @(negedge clk);

    // Frame 0: counter start, syncs, blanking, RGB realignment, first request.
    bus.en = 1'b1;
    k = 0;
    goto(3);    check("tick_pre_px", bus.pixel_x, 0);
    goto(4);    check("tick_px", bus.pixel_x, 1);
                check("tick_hs", bus.vga_hs, 1);
    goto(40);   check("blank_x", rgb, 12'h000);
    goto(43);   check("hs_before", bus.vga_hs, 1);
    goto(44);   check("hs_start", bus.vga_hs, 0);
    goto(55);   check("hs_end", bus.vga_hs, 0);
    goto(56);   check("hs_after", bus.vga_hs, 1);
    goto(100);  strobe(8'd1);
    check("req1_pend", bus.isel_pending, 1);
    check("req1_isel", bus.isel, 0);
    goto(203);  check("px5_x", bus.pixel_x, 5);
                check("px5_y", bus.pixel_y, 3);
                check("rgb_x4y3", rgb, 12'h43A);
    goto(204);  check("rgb_x5y3", rgb, 12'h53A);
    goto(212);  check("rgb_x7y3", rgb, 12'h73A);
    goto(303);  check("vs_before", bus.vga_vs, 1);
    goto(304);  check("vs_start", bus.vga_vs, 0);
    goto(312);  check("blank_y", rgb, 12'h000);
    goto(423);  check("vs_end", bus.vga_vs, 0);
    goto(424);  check("vs_after", bus.vga_vs, 1);
    goto(479);  check("wrap0_pre_isel", bus.isel, 0);
                check("wrap0_pre_pend", bus.isel_pending, 1);
                check("wrap0_pre_fs", bus.frame_start, 0);
    goto(480);  check("wrap0_isel", bus.isel, 1);
                check("wrap0_pend", bus.isel_pending, 0);
                check("wrap0_fs", bus.frame_start, 1);
                check("wrap0_px", bus.pixel_x, 0);
                check("wrap0_py", bus.pixel_y, 0);
    goto(481);  check("wrap0_fs_end", bus.frame_start, 0);

    // Frame 1: last write wins; a strobe on the wrap edge waits for the next wrap.
    goto(500);  strobe(8'd2);
    goto(600);  strobe(8'd3);
    check("req3_pend", bus.isel_pending, 1);
    check("req3_isel", bus.isel, 1);
    goto(959);  strobe(8'd5);
    check("wrap1_isel", bus.isel, 3);
    check("wrap1_pend", bus.isel_pending, 1);
    check("wrap1_fs", bus.frame_start, 1);
    goto(1439); check("wrap2_pre_isel", bus.isel, 3);
    goto(1440); check("wrap2_isel", bus.isel, 5);
                check("wrap2_pend", bus.isel_pending, 0);

    // en drops mid-line while hsync is low; the pending request is not lost.
    goto(1500); strobe(8'd7);
    check("req7_pend", bus.isel_pending, 1);
    goto(1604); check("en_drop_hs_pre", bus.vga_hs, 0);
    bus.en = 1'b0;
    adv(1);
    check("en_drop_px", bus.pixel_x, 0);
    check("en_drop_py", bus.pixel_y, 0);
    check("en_drop_rgb", rgb, 12'h000);
    check("en_drop_hs", bus.vga_hs, 1);
    check("en_drop_vs", bus.vga_vs, 1);
    check("en_drop_isel", bus.isel, 5);
    check("en_drop_pend", bus.isel_pending, 1);
    adv(1);
    check("idle_apply_isel", bus.isel, 7);
    check("idle_apply_pend", bus.isel_pending, 0);

    // Restart from (0,0), then an asynchronous reset mid-line drops a pending request.
    bus.en = 1'b1;
    k = 0;
    adv(3);     check("restart_px0", bus.pixel_x, 0);
    adv(1);     check("restart_px1", bus.pixel_x, 1);
    goto(10);   strobe(8'd9);
    check("req9_pend", bus.isel_pending, 1);
    goto(20);   check("mid_line_px", bus.pixel_x, 5);
    rst = 1'b0;
    #1;
    check("arst_isel", bus.isel, 0);
    check("arst_pend", bus.isel_pending, 0);
    check("arst_px", bus.pixel_x, 0);
    check("arst_hs", bus.vga_hs, 1);
    check("arst_rgb", rgb, 12'h000);
    bus.en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    adv(2);
    check("post_rst_pend", bus.isel_pending, 0);
    check("post_rst_isel", bus.isel, 0);

    // Unattended frames: isel moves only when the slideshow option is built in.
    bus.en = 1'b1;
    k = 0;
    goto(480);  check("slide_f1", bus.isel, 0);
`ifdef IM_VGA_SLIDESHOW_EN
    goto(960);  check("slide_f2", bus.isel, 1);
    goto(1440); check("slide_f3", bus.isel, 1);
    goto(1920); check("slide_f4", bus.isel, 0);
`else
    goto(960);  check("static_f2", bus.isel, 0);
    goto(1440); check("static_f3", bus.isel, 0);
    goto(1920); check("static_f4", bus.isel, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
